// File: rtl/pooling_layer.sv
// 2x2 stride-2 average pooling over square feature maps held in CNNmemory.
// Fetches one input row pair per load_block request and writes one pooled word per cycle.
module pooling_layer #(
    parameter int unsigned MAX_LOAD = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [15:0]        mapsNumber,
    input  logic [15:0]        mapSize,
    input  logic [15:0]        mapsAddress,
    input  logic [15:0]        outAddress,
    output logic [15:0]        loadAddr,
    output logic [15:0]        loadSize,
    output logic               loadEnable,
    input  logic               loadDone,
    input  logic signed [15:0] loadOut [0:MAX_LOAD-1],
    output logic [15:0]        writeAddr,
    output logic signed [15:0] writeOut,
    output logic               writeEnable,
    output logic               done
);

    localparam int unsigned IDX_W = $clog2(MAX_LOAD);

    typedef enum logic [1:0] {IDLE, LOAD, POOL, DONE} state_t;

    state_t             state;
    logic [15:0]        mapIdx;
    logic [15:0]        rowIdx;
    logic [15:0]        colIdx;
    logic [15:0]        nLat;
    logic [15:0]        wLat;
    logic [15:0]        mapsLat;
    logic [15:0]        mapStep;
    logic [15:0]        mapBase;
    logic [15:0]        rowAddr;
    logic [15:0]        wrPtr;
    logic signed [15:0] loadBuf [0:MAX_LOAD-1];

    logic [15:0]        colTwo;
    logic [IDX_W-1:0]   idxA;
    logic [IDX_W-1:0]   idxB;
    logic [IDX_W-1:0]   idxC;
    logic [IDX_W-1:0]   idxD;
    logic signed [17:0] sumLoad;
    logic signed [17:0] sumBuf;
    logic               lastRow;
    logic               lastMap;
    logic               degenerate;
    logic               abort;

    function automatic logic signed [17:0] ext18(input logic signed [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

    // Window indices for column colIdx: top pair at 2c, bottom pair one row (N words) later.
    always_comb begin
        colTwo     = {colIdx[14:0], 1'b0};
        idxA       = IDX_W'(colTwo);
        idxB       = IDX_W'(colTwo + 16'd1);
        idxC       = IDX_W'(nLat + colTwo);
        idxD       = IDX_W'(nLat + colTwo + 16'd1);
        sumLoad    = ext18(loadOut[idxA]) + ext18(loadOut[idxB])
                   + ext18(loadOut[idxC]) + ext18(loadOut[idxD]);
        sumBuf     = ext18(loadBuf[idxA]) + ext18(loadBuf[idxB])
                   + ext18(loadBuf[idxC]) + ext18(loadBuf[idxD]);
        lastRow    = (rowIdx + 16'd1) == wLat;
        lastMap    = (mapIdx + 16'd1) == mapsLat;
        degenerate = (mapsNumber == 16'd0) || (mapSize < 16'd2);
        abort      = !enable && ((state == LOAD) || (state == POOL));
    end

    // Row-pair buffer: captured on the single cycle loadOut is guaranteed valid.
    always_ff @(posedge clk) begin
        if (state == LOAD && loadDone && enable) begin
            loadBuf <= loadOut;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mapIdx      <= '0;
            rowIdx      <= '0;
            colIdx      <= '0;
            nLat        <= '0;
            wLat        <= '0;
            mapsLat     <= '0;
            mapStep     <= '0;
            mapBase     <= '0;
            rowAddr     <= '0;
            wrPtr       <= '0;
            loadAddr    <= '0;
            loadSize    <= '0;
            loadEnable  <= 1'b0;
            writeAddr   <= '0;
            writeOut    <= '0;
            writeEnable <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            loadAddr    <= '0;
            loadSize    <= '0;
            loadEnable  <= 1'b0;
            writeAddr   <= '0;
            writeOut    <= '0;
            writeEnable <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mapIdx <= '0;
                    rowIdx <= '0;
                    colIdx <= '0;
                    if (enable) begin
                        nLat    <= mapSize;
                        wLat    <= {1'b0, mapSize[15:1]};
                        mapsLat <= mapsNumber;
                        mapStep <= 16'(mapSize * mapSize);
                        mapBase <= mapsAddress;
                        rowAddr <= mapsAddress;
                        wrPtr   <= outAddress;
                        if (degenerate) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            loadAddr   <= mapsAddress;
                            loadSize   <= {mapSize[14:0], 1'b0};
                            loadEnable <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                // Column 0 is pooled straight from loadOut so it lands on the cycle after loadDone.
                LOAD: begin
                    if (loadDone) begin
                        loadEnable  <= 1'b0;
                        writeEnable <= 1'b1;
                        writeOut    <= 16'(sumLoad >>> 2);
                        writeAddr   <= wrPtr;
                        wrPtr       <= wrPtr + 16'd1;
                        colIdx      <= 16'd1;
                        state       <= POOL;
                    end
                end
                POOL: begin
                    if (colIdx != wLat) begin
                        writeEnable <= 1'b1;
                        writeOut    <= 16'(sumBuf >>> 2);
                        writeAddr   <= wrPtr;
                        wrPtr       <= wrPtr + 16'd1;
                        colIdx      <= colIdx + 16'd1;
                    end else begin
                        writeEnable <= 1'b0;
                        colIdx      <= '0;
                        if (!lastRow) begin
                            rowIdx     <= rowIdx + 16'd1;
                            rowAddr    <= rowAddr + loadSize;
                            loadAddr   <= rowAddr + loadSize;
                            loadEnable <= 1'b1;
                            state      <= LOAD;
                        end else if (!lastMap) begin
                            // Next map restarts from its own base so an odd trailing row is skipped.
                            rowIdx     <= '0;
                            mapIdx     <= mapIdx + 16'd1;
                            mapBase    <= mapBase + mapStep;
                            rowAddr    <= mapBase + mapStep;
                            loadAddr   <= mapBase + mapStep;
                            loadEnable <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            rowIdx <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_layer.sv
// Self-checking bench for pooling_layer: load_block responder, write scoreboard,
// table of run configurations plus abort and mid-run reset sequences.
module tb_pooling_layer;

    localparam int unsigned MAX_LOAD = 1024;
    localparam int SEQ    = 0;
    localparam int NEG    = 1;
    localparam int MINV   = 2;
    localparam int MAXV   = 3;
    localparam int POISON = 4;

    typedef struct {
        int n; int m; int mAddr; int oAddr; int delay; int fill;
        int expWrites; int expLoads; int expFirst;
    } tcase_t;
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int addr; int size; } ld_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [15:0]        mapsNumber;
    logic [15:0]        mapSize;
    logic [15:0]        mapsAddress;
    logic [15:0]        outAddress;
    logic [15:0]        loadAddr;
    logic [15:0]        loadSize;
    logic               loadEnable;
    logic               loadDone;
    logic signed [15:0] loadOut [0:MAX_LOAD-1];
    logic [15:0]        writeAddr;
    logic signed [15:0] writeOut;
    logic               writeEnable;
    logic               done;

    logic signed [15:0] mem [0:65535];
    wr_t expWr[$];
    ld_t expLd[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loadDelay = 0;
    int waitCnt = 0;
    int stallAddr = 0;

    pooling_layer #(.MAX_LOAD(MAX_LOAD)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mapsNumber(mapsNumber), .mapSize(mapSize),
        .mapsAddress(mapsAddress), .outAddress(outAddress),
        .loadAddr(loadAddr), .loadSize(loadSize), .loadEnable(loadEnable),
        .loadDone(loadDone), .loadOut(loadOut),
        .writeAddr(writeAddr), .writeOut(writeOut), .writeEnable(writeEnable),
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // load_block model: optional stall, one-cycle loadDone, loadOut garbage afterwards.
    initial begin
        ld_t l;
        loadDone = 1'b0;
        for (int i = 0; i < MAX_LOAD; i++) loadOut[i] = '0;
        forever begin
            @(negedge clk);
            if (loadDone) begin
                loadDone = 1'b0;
                waitCnt  = 0;
                for (int i = 0; i < MAX_LOAD; i++) loadOut[i] = 16'($urandom);
            end else if (loadEnable) begin
                if (waitCnt == 0) stallAddr = int'(loadAddr);
                else check("stall_addr", int'(loadAddr), stallAddr);
                if (waitCnt >= loadDelay) begin
                    if (expLd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_load addr=%0d", loadAddr);
                    end else begin
                        l = expLd.pop_front();
                        check("load_addr", int'(loadAddr), l.addr);
                        check("load_size", int'(loadSize), l.size);
                    end
                    for (int i = 0; i < int'(loadSize) && i < MAX_LOAD; i++)
                        loadOut[i] = mem[16'(int'(loadAddr) + i)];
                    loadDone = 1'b1;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Write scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (writeEnable) begin
                if (expWr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", writeAddr, writeOut);
                end else begin
                    e = expWr.pop_front();
                    check("write_addr", int'(writeAddr), e.addr);
                    check("write_data", int'(writeOut), e.data);
                end
            end
        end
    end

    task automatic fillMem(input int fill, input int ma, input int n, input int m);
        logic [15:0] a;
        int p, row, col;
        for (int i = 0; i < n * n * m; i++) begin
            a   = 16'(ma + i);
            p   = i % (n * n);
            row = p / n;
            col = p % n;
            case (fill)
                SEQ:     mem[a] = 16'(i + 1);
                NEG:     mem[a] = (col % 2 == 0) ? -16'sd1 : -16'sd2;
                MINV:    mem[a] = 16'sh8000;
                MAXV:    mem[a] = 16'sh7FFF;
                default: mem[a] = (row == n - 1 || col == n - 1) ? 16'($urandom) : 16'(i + 1);
            endcase
        end
    endtask

    task automatic pushModel(input tcase_t t);
        int w, base, s;
        wr_t e;
        ld_t l;
        w = t.n / 2;
        if (t.m == 0 || t.n < 2) return;
        for (int k = 0; k < t.m; k++) begin
            for (int r = 0; r < w; r++) begin
                base   = t.mAddr + k * t.n * t.n + 2 * r * t.n;
                l.addr = base & 32'hFFFF;
                l.size = 2 * t.n;
                expLd.push_back(l);
                for (int c = 0; c < w; c++) begin
                    s = int'(mem[16'(base + 2 * c)]) + int'(mem[16'(base + 2 * c + 1)])
                      + int'(mem[16'(base + t.n + 2 * c)]) + int'(mem[16'(base + t.n + 2 * c + 1)]);
                    e.addr = (t.oAddr + k * w * w + r * w + c) & 32'hFFFF;
                    e.data = s >>> 2;
                    expWr.push_back(e);
                end
            end
        end
    endtask

    task automatic setConfig(input tcase_t t);
        mapSize     = 16'(t.n);
        mapsNumber  = 16'(t.m);
        mapsAddress = 16'(t.mAddr);
        outAddress  = 16'(t.oAddr);
        loadDelay   = t.delay;
    endtask

    task automatic runCore(input tcase_t t);
        int startCyc, nW, nLd, firstVal, lastWr, firstLd, doneCyc;
        bit prevLE, seenDone;
        nW = 0; nLd = 0; firstVal = 0; lastWr = 0; firstLd = 0; doneCyc = 0;
        prevLE = 0; seenDone = 0;
        setConfig(t);
        @(negedge clk);
        enable   = 1'b1;
        startCyc = cyc;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (writeEnable) begin
                nW++;
                if (nW == 1) firstVal = int'(writeOut);
                lastWr = cyc;
            end
            if (loadEnable && !prevLE) begin
                nLd++;
                if (nLd == 1) firstLd = cyc;
            end
            prevLE = loadEnable;
            if (done) begin
                doneCyc  = cyc;
                seenDone = 1;
                break;
            end
        end
        check("done_seen", int'(seenDone), 1);
        check("write_count", nW, t.expWrites);
        check("load_count", nLd, t.expLoads);
        if (t.expWrites > 0) begin
            check("first_value", firstVal, t.expFirst);
            check("first_load_latency", firstLd - startCyc, 1);
            check("done_after_last_write", doneCyc - lastWr, 1);
        end else begin
            check("degenerate_done_latency", doneCyc - startCyc, 1);
        end
        check("pending_writes", expWr.size(), 0);
        check("pending_loads", expLd.size(), 0);
        enable = 1'b0;
        @(negedge clk);
        check("done_drops", int'(done), 0);
        expWr.delete();
        expLd.delete();
    endtask

    task automatic pushHandBasic();
        wr_t e;
        ld_t l;
        l = '{100, 8}; expLd.push_back(l);
        l = '{108, 8}; expLd.push_back(l);
        e = '{500, 3};  expWr.push_back(e);
        e = '{501, 5};  expWr.push_back(e);
        e = '{502, 11}; expWr.push_back(e);
        e = '{503, 13}; expWr.push_back(e);
    endtask

    initial begin
        tcase_t tbl [0:11];
        tcase_t basic;
        wr_t e;
        ld_t l;
        int seen;

        tbl[0]  = '{4, 1, 100,   500,   0,  SEQ,    4,  2, 3};
        tbl[1]  = '{4, 1, 100,   500,   1,  SEQ,    4,  2, 3};
        tbl[2]  = '{4, 1, 100,   500,   10, SEQ,    4,  2, 3};
        tbl[3]  = '{2, 1, 200,   600,   0,  NEG,    1,  1, -2};
        tbl[4]  = '{2, 1, 210,   610,   0,  MINV,   1,  1, -32768};
        tbl[5]  = '{2, 1, 220,   620,   2,  MAXV,   1,  1, 32767};
        tbl[6]  = '{4, 3, 1000,  2000,  0,  SEQ,    12, 6, 3};
        tbl[7]  = '{5, 2, 300,   700,   2,  POISON, 8,  4, 4};
        tbl[8]  = '{1, 3, 400,   800,   0,  SEQ,    0,  0, 0};
        tbl[9]  = '{4, 0, 400,   800,   0,  SEQ,    0,  0, 0};
        tbl[10] = '{4, 1, 65532, 65534, 0,  SEQ,    4,  2, 3};
        tbl[11] = '{3, 2, 900,   950,   1,  SEQ,    2,  2, 3};
        basic   = tbl[0];

        reset = 1'b0; enable = 1'b0;
        mapSize = '0; mapsNumber = '0; mapsAddress = '0; outAddress = '0;
        repeat (3) @(negedge clk);
        check("rst_loadEnable", int'(loadEnable), 0);
        check("rst_writeEnable", int'(writeEnable), 0);
        check("rst_done", int'(done), 0);
        check("rst_loadAddr", int'(loadAddr), 0);
        check("rst_loadSize", int'(loadSize), 0);
        check("rst_writeAddr", int'(writeAddr), 0);
        check("rst_writeOut", int'(writeOut), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            fillMem(tbl[i].fill, tbl[i].mAddr, tbl[i].n, tbl[i].m);
            pushModel(tbl[i]);
            runCore(tbl[i]);
        end

        // Hand-derived basic 4x4 expectations.
        fillMem(SEQ, 100, 4, 1);
        pushHandBasic();
        runCore(basic);

        // Abort after the second write.
        l = '{100, 8}; expLd.push_back(l);
        e = '{500, 3}; expWr.push_back(e);
        e = '{501, 5}; expWr.push_back(e);
        setConfig(basic);
        @(negedge clk);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk);
            if (writeEnable) seen++;
        end
        check("abort_reached", seen, 2);
        enable = 1'b0;
        @(negedge clk);
        check("abort_writeAddr", int'(writeAddr), 0);
        check("abort_loadAddr", int'(loadAddr), 0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_write", int'(writeEnable), 0);
            check("abort_no_load", int'(loadEnable), 0);
            @(negedge clk);
        end
        check("abort_pending", expWr.size() + expLd.size(), 0);

        // Asynchronous reset during POOL, then a clean rerun.
        l = '{100, 8}; expLd.push_back(l);
        e = '{500, 3}; expWr.push_back(e);
        @(negedge clk);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && seen < 1; i++) begin
            @(negedge clk);
            if (writeEnable) seen++;
        end
        check("reset_reached", seen, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_writeEnable", int'(writeEnable), 0);
        check("arst_loadEnable", int'(loadEnable), 0);
        check("arst_done", int'(done), 0);
        check("arst_writeAddr", int'(writeAddr), 0);
        check("arst_writeOut", int'(writeOut), 0);
        check("arst_loadAddr", int'(loadAddr), 0);
        check("arst_loadSize", int'(loadSize), 0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_idle_write", int'(writeEnable), 0);
        check("arst_pending", expWr.size() + expLd.size(), 0);
        pushHandBasic();
        runCore(basic);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pooling_layer.md
# pooling_layer

2×2, stride-2 average-pooling stage placed directly downstream of `convolution_layer`. It reads the convolution output feature maps from `CNNmemory` through the shared `load_block`, two input rows at a time. It then writes one pooled word per cycle back to `CNNmemory`. Sequencing, enable/done handshaking and address arithmetic follow the convolution stage's conventions, so the top-level controller can chain conv → pool on the same memory bus.

## Interface
- `MAX_LOAD`, 1024: depth of `loadOut`; `2*mapSize` must not exceed it.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `enable` in 1: level start/run; deassert to abort or to acknowledge `done`.
- `mapsNumber` in 16: number of input feature maps.
- `mapSize` in 16: input map side length N (square, row-major).
- `mapsAddress` in 16: word address of map 0 element (0,0); map k starts at `mapsAddress + k*N*N`.
- `outAddress` in 16: word address of pooled map 0; pooled map k starts at `outAddress + k*W*W`, where W = N>>1.
- `loadAddr` out 16: start address for `load_block`.
- `loadSize` out 16: word count for `load_block`, always 2*N.
- `loadEnable` out 1: load request; held until `loadDone` is sampled high.
- `loadDone` in 1: `load_block` completion; `loadOut` is valid while it is high.
- `loadOut` in signed 16 × [0:MAX_LOAD-1]: loaded words, index 0 = `loadAddr`.
- `writeAddr` out 16: memory write address.
- `writeOut` out signed 16: pooled value.
- `writeEnable` out 1: one-cycle write strobe per pooled word.
- `done` out 1: high from completion until `enable` falls.

## Operation
- FSM states: IDLE, LOAD, POOL, DONE.
- **IDLE**
  - Waits for `enable`=1.
  - Clears map index k, pooled-row index r and column index c.
  - If `mapsNumber`=0 or N<2, goes to DONE with no loads or writes.
  - Otherwise goes to LOAD.
- **LOAD**
  - Drives `loadEnable`=1, `loadAddr` = `mapsAddress + k*N*N + 2r*N`, `loadSize` = 2N.
  - On `loadDone`=1, latches the needed `loadOut` words internally and goes to POOL.
  - `loadDone` is ignored in every other state.
- **POOL**
  - Each cycle: sum = `loadOut[2c] + loadOut[2c+1] + loadOut[N+2c] + loadOut[N+2c+1]`, sign-extended to 18 bits.
  - `writeOut` = `sum >>> 2`: arithmetic shift, floor, no saturation needed.
  - `writeAddr` = `outAddress + k*W*W + r*W + c`, with `writeEnable`=1.
  - After c = W-1: c←0 and r++. If r reaches W, then r←0 and k++. If k reaches `mapsNumber`, go to DONE; else go to LOAD.
- **Odd N**: the last row and last column are dropped (floor pooling).
- **DONE**: `done`=1 and all strobes low. When `enable`=0, return to IDLE; `done` drops.
- **Abort**: `enable`=0 in LOAD or POOL → IDLE on the next edge. No further writes; outputs return to reset values.
- Address arithmetic is 16-bit and wraps modulo 2^16 with no error flag.

## Timing
- All outputs are registered.
- Reset values: `loadEnable`, `writeEnable` and `done` = 0; `loadAddr`, `loadSize`, `writeAddr` and `writeOut` = 0.
- Cycle E, `enable` sampled high in IDLE → `loadEnable`=1 at E+1.
- Cycle D, `loadDone` sampled high:
  - `loadEnable`=0 at D+1.
  - Writes c=0..W-1 occur on cycles D+1..D+W, one per cycle, no gaps.
  - At D+W+1, either `loadEnable`=1 (next row pair) or `done`=1.
- Degenerate case (`mapsNumber`=0 or N<2): `done`=1 at E+1.
- `loadOut` need only be valid on cycle D; the block latches the words it needs at that cycle.
- Async reset asserted mid-operation: outputs go to reset values immediately, and the FSM returns to IDLE with no further writes. After release, a new run needs `enable` high in IDLE.

## Test plan
- **Basic 4×4**: N=4, `mapsNumber`=1, map values 1..16 row-major, `outAddress`=500.
  - Writes (500,3), (501,5), (502,11), (503,13).
  - Exactly 2 loads: addresses `mapsAddress` and `mapsAddress+8`, size 8.
  - `done`=1 one cycle after the last write.
- **Negative rounding**: window {-1,-2,-1,-2} → `writeOut` = -2. Window {-32768 ×4} → -32768. Window {32767 ×4} → 32767.
- **Multi-map addressing**: N=4, `mapsNumber`=3.
  - Loads at `mapsAddress` + {0,8,16,24,32,40}.
  - Writes at `outAddress` + 0..11 in order; 12 writes total.
- **Odd/degenerate sizes**:
  - N=5: 4 writes per map; row 4 and column 4 values do not affect results.
  - N=1 or `mapsNumber`=0: `done` on E+1, zero `loadEnable`/`writeEnable` pulses.
- **Abort and reset**:
  - Drop `enable` after the 2nd write of a 4×4 run: no further writes, IDLE next cycle.
  - Assert `reset` mid-POOL: all outputs 0 asynchronously. A subsequent run reproduces the basic 4×4 results exactly.
- **Handshake stalls**: delay `loadDone` by 0, 1 and 10 cycles. `loadEnable` holds steady with a constant `loadAddr` throughout the stall, and results are unchanged.
